// File: rtl/morse_sequencer.sv
// morse_sequencer: ASCII characters to Morse on/off keying with unit-based timing.
// Define MORSE_LOWERCASE_EN to accept 'a'-'z' as aliases of 'A'-'Z'.
module morse_sequencer #(
    parameter int UNIT_CYCLES = 1_440_000
) (
    input  logic       clk_24,
    input  logic       rst_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key,
    output logic       busy
);
    localparam int CW = $clog2(4*UNIT_CYCLES+1);
    localparam logic [CW-1:0] U1 = CW'(UNIT_CYCLES-1);
    localparam logic [CW-1:0] U3 = CW'(3*UNIT_CYCLES-1);
    localparam logic [CW-1:0] U4 = CW'(4*UNIT_CYCLES-1);
    typedef enum logic [2:0] {IDLE, MARK, SPACE, CHAR_GAP, WORD_GAP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [4:0] pat, lu_pat;
    logic [2:0] len, lu_len;
    logic [7:0] c;
    logic lu_ok;
    assign busy = state != IDLE;
    assign char_ready = state == IDLE;
    // Patterns are left-aligned: bit 4 is the first element, 1 = dash.
    always_comb begin
`ifdef MORSE_LOWERCASE_EN
        c = (char_data >= 8'h61 && char_data <= 8'h7A) ? char_data - 8'h20 : char_data;
`else
        c = char_data;
`endif
        lu_ok = 1'b1;
        lu_len = 3'd5;
        lu_pat = 5'b00000;
        case (c)
            8'h30: lu_pat = 5'b11111;
            8'h31: lu_pat = 5'b01111;
            8'h32: lu_pat = 5'b00111;
            8'h33: lu_pat = 5'b00011;
            8'h34: lu_pat = 5'b00001;
            8'h35: lu_pat = 5'b00000;
            8'h36: lu_pat = 5'b10000;
            8'h37: lu_pat = 5'b11000;
            8'h38: lu_pat = 5'b11100;
            8'h39: lu_pat = 5'b11110;
            8'h41: {lu_len, lu_pat} = {3'd2, 5'b01000};
            8'h42: {lu_len, lu_pat} = {3'd4, 5'b10000};
            8'h43: {lu_len, lu_pat} = {3'd4, 5'b10100};
            8'h44: {lu_len, lu_pat} = {3'd3, 5'b10000};
            8'h45: {lu_len, lu_pat} = {3'd1, 5'b00000};
            8'h46: {lu_len, lu_pat} = {3'd4, 5'b00100};
            8'h47: {lu_len, lu_pat} = {3'd3, 5'b11000};
            8'h48: {lu_len, lu_pat} = {3'd4, 5'b00000};
            8'h49: {lu_len, lu_pat} = {3'd2, 5'b00000};
            8'h4A: {lu_len, lu_pat} = {3'd4, 5'b01110};
            8'h4B: {lu_len, lu_pat} = {3'd3, 5'b10100};
            8'h4C: {lu_len, lu_pat} = {3'd4, 5'b01000};
            8'h4D: {lu_len, lu_pat} = {3'd2, 5'b11000};
            8'h4E: {lu_len, lu_pat} = {3'd2, 5'b10000};
            8'h4F: {lu_len, lu_pat} = {3'd3, 5'b11100};
            8'h50: {lu_len, lu_pat} = {3'd4, 5'b01100};
            8'h51: {lu_len, lu_pat} = {3'd4, 5'b11010};
            8'h52: {lu_len, lu_pat} = {3'd3, 5'b01000};
            8'h53: {lu_len, lu_pat} = {3'd3, 5'b00000};
            8'h54: {lu_len, lu_pat} = {3'd1, 5'b10000};
            8'h55: {lu_len, lu_pat} = {3'd3, 5'b00100};
            8'h56: {lu_len, lu_pat} = {3'd4, 5'b00010};
            8'h57: {lu_len, lu_pat} = {3'd3, 5'b01100};
            8'h58: {lu_len, lu_pat} = {3'd4, 5'b10010};
            8'h59: {lu_len, lu_pat} = {3'd4, 5'b10110};
            8'h5A: {lu_len, lu_pat} = {3'd4, 5'b11000};
            default: lu_ok = 1'b0;
        endcase
    end
    always_ff @(posedge clk_24) begin
        if (!rst_n) begin
            state <= IDLE;
            key <= 1'b0;
            cnt <= '0;
            pat <= '0;
            len <= '0;
        end else begin
            case (state)
                IDLE:
                    if (char_valid && lu_ok) begin
                        state <= MARK;
                        key <= 1'b1;
                        pat <= lu_pat;
                        len <= lu_len;
                        cnt <= lu_pat[4] ? U3 : U1;
                    end else if (char_valid && char_data == 8'h20) begin
                        state <= WORD_GAP;
                        cnt <= U4;
                    end
                MARK:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        key <= 1'b0;
                        state <= (len == 3'd1) ? CHAR_GAP : SPACE;
                        cnt <= (len == 3'd1) ? U3 : U1;
                    end
                SPACE:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        state <= MARK;
                        key <= 1'b1;
                        pat <= pat << 1;
                        len <= len - 1'b1;
                        cnt <= pat[3] ? U3 : U1;
                    end
                default:
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed checks of Morse keying timing with UNIT_CYCLES=4.
module tb_morse_sequencer;
    logic clk_24 = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic char_valid = 1'b0;
    logic char_ready, key, busy;
    int checks = 0;
    int failures = 0;
    string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                         "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                         "..-", "...-", ".--", "-..-", "-.--", "--..",
                         "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

    morse_sequencer #(.UNIT_CYCLES(4)) dut (
        .clk_24(clk_24), .rst_n(rst_n), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .key(key), .busy(busy)
    );

    always #5 clk_24 = ~clk_24;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk_24);
        char_data = c;
        char_valid = 1'b1;
        @(posedge clk_24);
        #1;
        char_valid = 1'b0;
        char_data = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        char_valid = 1'b0;
        repeat (3) @(posedge clk_24);
        @(negedge clk_24);
        checks++;
        if ({key, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_in: key/busy got %b want 00", {key, busy});
        end
        rst_n = 1'b1;
        @(negedge clk_24);
        checks++;
        if ({key, busy, char_ready} !== 3'b001) begin
            failures++;
            $display("FAIL reset_out: key/busy/ready got %b want 001", {key, busy, char_ready});
        end
    endtask

    task automatic test_single_dot(input logic [7:0] c);
        logic [2:0] exp;
        send(c);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk_24);
            exp = {k <= 4, k <= 16, k == 17};
            checks++;
            if ({key, busy, char_ready} !== exp) begin
                failures++;
                $display("FAIL dot %h cycle %0d: key/busy/ready got %b want %b", c, k, {key, busy, char_ready}, exp);
            end
        end
    endtask

    task automatic test_unsupported(input logic [7:0] c);
        send(c);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_24);
            checks++;
            if ({key, busy, char_ready} !== 3'b001) begin
                failures++;
                $display("FAIL unsupported %h cycle %0d: key/busy/ready got %b want 001", c, k, {key, busy, char_ready});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp;
        logic ek;
        @(negedge clk_24);
        char_data = 8'h41;
        char_valid = 1'b1;
        @(posedge clk_24);
        #1;
        char_data = 8'h54;
        for (int k = 1; k <= 58; k++) begin
            @(negedge clk_24);
            ek = (k <= 4) || (k >= 9 && k <= 20) || (k >= 34 && k <= 45);
            exp = {ek, !(k == 33 || k == 58), k == 33 || k == 58};
            checks++;
            if ({key, busy, char_ready} !== exp) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: key/busy/ready got %b want %b", k, {key, busy, char_ready}, exp);
            end
            if (k == 34) char_valid = 1'b0;
        end
    endtask

    task automatic test_digit_zero;
        logic [2:0] exp;
        send(8'h30);
        for (int k = 1; k <= 89; k++) begin
            @(negedge clk_24);
            exp = {k <= 76 && ((k - 1) % 16) < 12, k <= 88, k == 89};
            checks++;
            if ({key, busy, char_ready} !== exp) begin
                failures++;
                $display("FAIL zero cycle %0d: key/busy/ready got %b want %b", k, {key, busy, char_ready}, exp);
            end
        end
    endtask

    task automatic test_word_gap;
        logic [2:0] exp;
        send(8'h20);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk_24);
            exp = {1'b0, k <= 16, k == 17};
            checks++;
            if ({key, busy, char_ready} !== exp) begin
                failures++;
                $display("FAIL word_gap cycle %0d: key/busy/ready got %b want %b", k, {key, busy, char_ready}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_dash;
        send(8'h54);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_24);
            checks++;
            if (key !== 1'b1) begin
                failures++;
                $display("FAIL dash_before_reset cycle %0d: key got %b want 1", k, key);
            end
        end
        rst_n = 1'b0;
        @(negedge clk_24);
        checks++;
        if ({key, busy, char_ready} !== 3'b001) begin
            failures++;
            $display("FAIL mid_dash_reset: key/busy/ready got %b want 001", {key, busy, char_ready});
        end
        rst_n = 1'b1;
        test_single_dot(8'h45);
    endtask

    task automatic test_lookup;
        string obs;
        int run;
        logic [7:0] ch;
        for (int i = 0; i < 36; i++) begin
            ch = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
            send(ch);
            obs = "";
            run = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk_24);
                if (key) run++;
                else if (run > 0) begin
                    if (run == 12) obs = {obs, "-"};
                    else if (run == 4) obs = {obs, "."};
                    else obs = {obs, "?"};
                    run = 0;
                end
                if (char_ready) break;
            end
            checks++;
            if (obs != codes[i] || !char_ready) begin
                failures++;
                $display("FAIL lookup %h: got '%s' ready=%b want '%s' ready=1", ch, obs, char_ready, codes[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_dot(8'h45);
        test_back_to_back;
        test_digit_zero;
        test_word_gap;
        test_unsupported(8'h23);
        test_reset_mid_dash;
`ifdef MORSE_LOWERCASE_EN
        test_single_dot(8'h65);
`else
        test_unsupported(8'h65);
`endif
        test_lookup;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
